timer_bcd_multi: RTL and testbench

Parametrised successor to the current stopwatch core. It is an N-digit BCD timer with a run/stop control, a programming mode for presetting digits, a clear input, and a selectable up-count or down-count direction. The down-count stops at zero and raises a done flag. It sits between the debouncer instances (single-cycle pulses in) and the per-digit dec7seg instances (packed BCD out). The cursor output lets the display layer blink the digit being edited.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 44 ++++
 rtl/timer_bcd_multi.sv | 163 ++++++++++++++++
 tb/tb_timer_bcd_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-digit BCD timer.
package timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PROG = 2'd2
  } state_t;

  // One BCD digit step upward, wrapping 9 back to 0.
  function automatic logic [BCD_W-1:0] bcd_inc_mod10(input logic [BCD_W-1:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // One BCD digit step downward, wrapping 0 back to 9.
  function automatic logic [BCD_W-1:0] bcd_dec_mod10(input logic [BCD_W-1:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with count enable, direction, programming
// increment (no carry) and synchronous clear.
module bcd_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             down,
  input  logic             load_inc,
  input  logic             clr,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);

  logic [BCD_W-1:0] value_reg;
  logic [BCD_W-1:0] value_next;

  // Clear wins over programming, programming over counting.
  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (load_inc) begin
      value_next = bcd_inc_mod10(value_reg);
    end else if (en) begin
      value_next = down ? bcd_dec_mod10(value_reg) : bcd_inc_mod10(value_reg);
    end
  end

  // Digit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  // Ripple carry/borrow into the next more significant digit.
  assign carry_out = en && (down ? (value_reg == 4'd0) : (value_reg == 4'd9));
  assign value     = value_reg;

endmodule

// File: rtl/timer_bcd_multi.sv
// N-digit BCD up/down timer with run/stop, digit programming and clear.
module timer_bcd_multi
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 25000000,
  parameter int TICK_HZ    = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_stop_p,
  input  logic                        prog_p,
  input  logic                        clr_p,
  input  logic                        count_down,
  output logic [BCD_W*NUM_DIGITS-1:0] dig_out,
  output logic [NUM_DIGITS-1:0]       cursor,
  output logic                        running,
  output logic                        done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [NUM_DIGITS-1:0] CUR_MSD = NUM_DIGITS'(1) << (NUM_DIGITS - 1);
  localparam logic [BCD_W*NUM_DIGITS-1:0] VALUE_ONE = (BCD_W*NUM_DIGITS)'(1);

  state_t                  state_reg, state_next;
  logic [PW-1:0]           presc_reg, presc_next;
  logic [NUM_DIGITS-1:0]   cursor_reg, cursor_next;
  logic                    done_reg, done_next;

  logic                    tick;
  logic                    all_zero;
  logic                    is_one;
  logic                    start_blocked;
  logic                    count_en;
  logic                    reach_zero;
  logic                    digit_clr;
  logic [NUM_DIGITS-1:0]   load_inc;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [NUM_DIGITS-1:0]   carry;

  assign all_zero      = (dig_out == '0);
  assign is_one        = (dig_out == VALUE_ONE);
  assign start_blocked = count_down && all_zero;
  assign tick          = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);

  // A stop pulse coinciding with a tick freezes the digits; a down tick on
  // an all-zero value (reachable after an up-wrap then a direction flip)
  // must not wrap to all nines.
  assign count_en   = tick && !start_stop_p && !start_blocked;
  assign reach_zero = tick && !start_stop_p && count_down && (is_one || all_zero);
  assign digit_clr  = clr_p && (state_reg != ST_RUN);
  assign load_inc   = (state_reg == ST_PROG && start_stop_p && !prog_p && !clr_p)
                      ? cursor_reg : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign dig_en[gi] = count_en;
      end else begin : g_upper
        assign dig_en[gi] = carry[gi-1];
      end

      bcd_digit u_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (dig_en[gi]),
        .down      (count_down),
        .load_inc  (load_inc[gi]),
        .clr       (digit_clr),
        .value     (dig_out[gi*BCD_W +: BCD_W]),
        .carry_out (carry[gi])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_STOP;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state; clr_p outranks prog_p, which outranks start_stop_p.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP: begin
        if (clr_p) begin
          state_next = ST_STOP;
        end else if (prog_p) begin
          state_next = ST_PROG;
        end else if (start_stop_p && !start_blocked) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_stop_p || reach_zero) begin
          state_next = ST_STOP;
        end
      end
      ST_PROG: begin
        if (!clr_p && prog_p && cursor_reg[0]) begin
          state_next = ST_STOP;
        end
      end
      default: state_next = ST_STOP;
    endcase
  end

  // FSM outputs: cursor movement, done flag and prescaler next values.
  always_comb begin
    cursor_next = cursor_reg;
    done_next   = done_reg;
    presc_next  = '0;
    case (state_reg)
      ST_STOP: begin
        if (clr_p) begin
          done_next = 1'b0;
        end else if (prog_p) begin
          cursor_next = CUR_MSD;
          done_next   = 1'b0;
        end else if (start_stop_p && !start_blocked) begin
          done_next = 1'b0;
        end
      end
      ST_RUN: begin
        presc_next = tick ? '0 : presc_reg + PW'(1);
        if (reach_zero) begin
          done_next = 1'b1;
        end
      end
      ST_PROG: begin
        if (!clr_p && prog_p) begin
          cursor_next = cursor_reg >> 1;
        end
      end
      default: cursor_next = '0;
    endcase
  end

  // Registered outputs and prescaler; prescaler sits at 0 outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg  <= '0;
      cursor_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      presc_reg  <= presc_next;
      cursor_reg <= cursor_next;
      done_reg   <= done_next;
    end
  end

  assign cursor  = cursor_reg;
  assign done    = done_reg;
  assign running = (state_reg == ST_RUN);

endmodule

// File: tb/tb_timer_bcd_multi.sv
// Directed, table-driven bench for timer_bcd_multi (10 clocks per tick).
module tb_timer_bcd_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_stop_p;
  logic        prog_p;
  logic        clr_p;
  logic        count_down;
  logic [15:0] dig_out;
  logic [3:0]  cursor;
  logic        running;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_bcd_multi #(
    .NUM_DIGITS (4),
    .CLK_HZ     (10),
    .TICK_HZ    (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_stop_p (start_stop_p),
    .prog_p       (prog_p),
    .clr_p        (clr_p),
    .count_down   (count_down),
    .dig_out      (dig_out),
    .cursor       (cursor),
    .running      (running),
    .done         (done)
  );

  typedef struct {
    logic        ss;
    logic        prog;
    logic        clr;
    int          idle;
    logic [15:0] dig;
    logic [3:0]  cur;
    logic        run;
    logic        dn;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] dig, input logic [3:0] cur,
                           input logic run, input logic dn);
    chk({tag, " dig_out"}, dig_out, dig);
    chk({tag, " cursor"}, 16'(cursor), 16'(cur));
    chk({tag, " running"}, 16'(running), 16'(run));
    chk({tag, " done"}, 16'(done), 16'(dn));
    $display("%s: dig_out=%h cursor=%b running=%b done=%b", tag, dig_out, cursor, running, done);
  endtask

  // Drive pulses for exactly one active edge, starting 1 ns after an edge.
  task automatic pulse(input logic ss, input logic pg, input logic cl);
    start_stop_p = ss;
    prog_p       = pg;
    clr_p        = cl;
    @(posedge clk);
    #1;
    start_stop_p = 1'b0;
    prog_p       = 1'b0;
    clr_p        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load a 4-digit value through PROG mode; ends in STOP with cursor 0.
  task automatic preset(input logic [15:0] val);
    logic [3:0] nib;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    for (int d = 3; d >= 0; d--) begin
      nib = val[d*4 +: 4];
      repeat (int'(nib)) pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    //          ss    prog  clr   idle dig       cur      run   done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 9,  16'h0000, 4'b0000, 1'b1, 1'b0}; // start, just before tick
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 0,  16'h0001, 4'b0000, 1'b1, 1'b0}; // first tick
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 89, 16'h0010, 4'b0000, 1'b1, 1'b0}; // ten ticks, carry
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 0,  16'h0010, 4'b0000, 1'b0, 1'b0}; // stop
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 20, 16'h0010, 4'b0000, 1'b0, 1'b0}; // frozen
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 0,  16'h0000, 4'b0000, 1'b0, 1'b0}; // clear
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 0,  16'h0000, 4'b1000, 1'b0, 1'b0}; // enter PROG
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 0,  16'h1000, 4'b1000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 0,  16'h2000, 4'b1000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 0,  16'h3000, 4'b1000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 0,  16'h3000, 4'b0100, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 0,  16'h3100, 4'b0100, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 0,  16'h3100, 4'b0010, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 0,  16'h3100, 4'b0001, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 0,  16'h3100, 4'b0000, 1'b0, 1'b0}; // back to STOP
    vecs[15] = '{1'b1, 1'b1, 1'b1, 0,  16'h0000, 4'b0000, 1'b0, 1'b0}; // clr wins in STOP
    vecs[16] = '{1'b1, 1'b1, 1'b0, 0,  16'h0000, 4'b1000, 1'b0, 1'b0}; // prog wins over start
    vecs[17] = '{1'b1, 1'b0, 1'b0, 0,  16'h1000, 4'b1000, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 0,  16'h0000, 4'b1000, 1'b0, 1'b0}; // clr wins in PROG
    vecs[19] = '{1'b1, 1'b1, 1'b0, 0,  16'h0000, 4'b0100, 1'b0, 1'b0}; // shift, no increment
    vecs[20] = '{1'b0, 1'b1, 1'b0, 0,  16'h0000, 4'b0010, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 0,  16'h0000, 4'b0001, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 0,  16'h0000, 4'b0000, 1'b0, 1'b0};

    rst_n        = 1'b0;
    start_stop_p = 1'b0;
    prog_p       = 1'b0;
    clr_p        = 1'b0;
    count_down   = 1'b0;
    idle(3);
    check_all("reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1);
    check_all("after_reset", 16'h0000, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      pulse(vecs[i].ss, vecs[i].prog, vecs[i].clr);
      idle(vecs[i].idle);
      check_all($sformatf("vec%0d", i), vecs[i].dig, vecs[i].cur, vecs[i].run, vecs[i].dn);
    end

    // All-nines wraps to zero and keeps running.
    count_down = 1'b0;
    preset(16'h9999);
    check_all("preset_9999", 16'h9999, 4'b0000, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    idle(10);
    check_all("wrap", 16'h0000, 4'b0000, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // Down-count to zero, then a start on zero is ignored.
    preset(16'h0002);
    count_down = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    idle(9);
    check_all("down_pre", 16'h0002, 4'b0000, 1'b1, 1'b0);
    idle(1);
    check_all("down_1", 16'h0001, 4'b0000, 1'b1, 1'b0);
    idle(9);
    check_all("down_1_hold", 16'h0001, 4'b0000, 1'b1, 1'b0);
    idle(1);
    check_all("down_zero", 16'h0000, 4'b0000, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("start_at_zero", 16'h0000, 4'b0000, 1'b0, 1'b1);
    idle(10);
    check_all("zero_stays", 16'h0000, 4'b0000, 1'b0, 1'b1);

    // Borrow across digits.
    preset(16'h0100);
    pulse(1'b1, 1'b0, 1'b0);
    idle(10);
    check_all("borrow", 16'h0099, 4'b0000, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // Ignored pulses in RUN and mid-run direction change.
    count_down = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    idle(10);
    check_all("run_up_1", 16'h0001, 4'b0000, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_all("run_prog_ignored", 16'h0001, 4'b0000, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check_all("run_clr_ignored", 16'h0001, 4'b0000, 1'b1, 1'b0);
    idle(8);
    check_all("run_up_2", 16'h0002, 4'b0000, 1'b1, 1'b0);
    count_down = 1'b1;
    idle(10);
    check_all("flip_down", 16'h0001, 4'b0000, 1'b1, 1'b0);
    count_down = 1'b0;
    idle(10);
    check_all("flip_up", 16'h0002, 4'b0000, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-run, then prescaler restarts from zero.
    preset(16'h0042);
    pulse(1'b1, 1'b0, 1'b0);
    idle(5);
    check_all("pre_async", 16'h0042, 4'b0000, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("async_release", 16'h0000, 4'b0000, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    idle(9);
    check_all("post_reset_pre", 16'h0000, 4'b0000, 1'b1, 1'b0);
    idle(1);
    check_all("post_reset_tick", 16'h0001, 4'b0000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
